// File: rtl/tree_sum_sequencer.sv
// Job sequencer that streams chunks through an external adder tree and accumulates its outputs.
// Optional build macro TREE_SUM_SEQ_SAT_EN: accumulator saturates instead of wrapping.
module tree_sum_sequencer #(
  parameter int IN_NUM    = 8,
  parameter int BIT_WIDTH = 8,
  parameter int ACC_WIDTH = 24,
  parameter int LEN_WIDTH = 12
) (
  input  logic                        clock,
  input  logic                        n_rst,
  input  logic                        start,
  input  logic [LEN_WIDTH-1:0]        len,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [IN_NUM*BIT_WIDTH-1:0] in_values,
  output logic [IN_NUM*BIT_WIDTH-1:0] tree_in_values,
  input  logic [BIT_WIDTH-1:0]        tree_out_value,
  output logic [ACC_WIDTH-1:0]        result,
  output logic                        result_valid,
  input  logic                        result_ready,
  output logic                        busy
);

  localparam int ADD_DEPTH = (IN_NUM > 1) ? $clog2(IN_NUM) : 0;
  localparam int VW        = (ADD_DEPTH > 0) ? ADD_DEPTH : 1;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t               state_q;
  logic [LEN_WIDTH-1:0] len_q, cnt_q, cnt_d;
  logic [VW-1:0]        vsr_q, vsr_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH:0]   sum_w;
  logic                 in_ready_q, result_valid_q, busy_q;
  logic                 accept, acc_en;

  assign tree_in_values = in_values;
  assign accept         = in_valid & in_ready_q;
  assign cnt_d          = cnt_q + 1'b1;

  // vsr_q[VW-1] flags the cycle in which tree_out_value belongs to an accepted chunk
  if (ADD_DEPTH == 0) begin : g_comb_tree
    assign acc_en = accept;
    assign vsr_d  = '0;
  end else if (ADD_DEPTH == 1) begin : g_one_stage
    assign acc_en = vsr_q[0];
    assign vsr_d  = accept;
  end else begin : g_multi_stage
    assign acc_en = vsr_q[VW-1];
    assign vsr_d  = {vsr_q[VW-2:0], accept};
  end

  assign sum_w = {1'b0, acc_q} + {{(ACC_WIDTH+1-BIT_WIDTH){1'b0}}, tree_out_value};

`ifdef TREE_SUM_SEQ_SAT_EN
  assign acc_d = sum_w[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum_w[ACC_WIDTH-1:0];
`else
  assign acc_d = sum_w[ACC_WIDTH-1:0];
`endif

  always_ff @(posedge clock) begin
    if (!n_rst) begin
      state_q        <= IDLE;
      len_q          <= '0;
      cnt_q          <= '0;
      vsr_q          <= '0;
      acc_q          <= '0;
      in_ready_q     <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      vsr_q <= vsr_d;
      if (acc_en) acc_q <= acc_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (len != '0) begin
              len_q      <= len;
              in_ready_q <= 1'b1;
              state_q    <= FEED;
            end else begin
              result_valid_q <= 1'b1;
              state_q        <= DONE;
            end
          end
        end
        FEED: begin
          if (accept) begin
            cnt_q <= cnt_d;
            if (cnt_d == len_q) begin
              in_ready_q <= 1'b0;
              state_q    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // the last accumulate lands on the same edge the shift register empties
          if (vsr_q == '0) begin
            result_valid_q <= 1'b1;
            state_q        <= DONE;
          end
        end
        DONE: begin
          if (result_ready) begin
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign result       = acc_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_tree_sum_sequencer.sv
// Randomized bench for tree_sum_sequencer with a 2-cycle adder-tree model and a sum-of-chunks reference.
module tb_tree_sum_sequencer;
  localparam int IN_NUM = 4, BW = 8, AW = 16, LW = 12;
  localparam int LAT = 3;  // ADD_DEPTH + 1

  logic                 clock = 0, n_rst = 0, start = 0, in_valid = 0, result_ready = 0;
  logic [LW-1:0]        len = '0;
  logic [IN_NUM*BW-1:0] in_values = '0;
  logic [IN_NUM*BW-1:0] tree_in_values;
  logic [BW-1:0]        tree_out_value, t1 = '0, t2 = '0;
  logic [AW-1:0]        result;
  logic                 in_ready, result_valid, busy;
  int total = 0, bad = 0;

  tree_sum_sequencer #(.IN_NUM(IN_NUM), .BIT_WIDTH(BW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clock(clock), .n_rst(n_rst), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(in_ready), .in_values(in_values), .tree_in_values(tree_in_values),
    .tree_out_value(tree_out_value), .result(result), .result_valid(result_valid),
    .result_ready(result_ready), .busy(busy));

  always #5 clock = ~clock;

  function automatic logic [BW-1:0] lane_sum(input logic [IN_NUM*BW-1:0] v);
    logic [BW-1:0] s = '0;
    for (int i = 0; i < IN_NUM; i++) s = s + v[i*BW +: BW];
    return s;
  endfunction

  // external 2-stage adder tree
  always @(posedge clock) begin
    t1 <= lane_sum(tree_in_values);
    t2 <= t1;
  end
  assign tree_out_value = t2;

  task automatic step();
    @(posedge clock); #1;
  endtask

  // bub: percent of bubble cycles, or <0 for "2 idle cycles between chunks"; mode picks lane data
  task automatic run_job(input int n, input int bub, input int hold, input bit noisy, input int mode);
    longint ref_acc = 0;
    int accepted = 0, guard = 0, lat = 0;
    logic [AW-1:0] held;
    start = 1; len = LW'(n); step(); start = 0;
    while (accepted < n && guard < 20000) begin
      in_valid = (bub < 0) ? (guard % 3 == 0) : ($urandom_range(99) >= bub);
      for (int i = 0; i < IN_NUM; i++) begin
        case (mode)
          1: in_values[i*BW +: BW] = 8'd255;
          2: in_values[(IN_NUM-1-i)*BW +: BW] = BW'(i + 1);
          3: in_values[i*BW +: BW] = 8'd1;
          default: in_values[i*BW +: BW] = BW'($urandom);
        endcase
      end
      if (noisy) begin start = 1'($urandom_range(1)); len = LW'($urandom); end
      #1;
      total++;
      if (tree_in_values !== in_values) begin bad++; $display("FAIL passthru got=%h exp=%h", tree_in_values, in_values); end
      total++;
      if (busy !== 1'b1 || in_ready !== 1'b1) begin bad++; $display("FAIL feed_flags busy=%b ready=%b exp=1,1", busy, in_ready); end
      if (in_valid && in_ready) begin
        accepted++;
        ref_acc = ref_acc + longint'(lane_sum(in_values));
`ifdef TREE_SUM_SEQ_SAT_EN
        if (ref_acc > 65535) ref_acc = 65535;
`else
        ref_acc = ref_acc & 65535;
`endif
      end
      step(); guard++;
    end
    in_valid = 0; start = 0;
    total++;
    if (guard >= 20000) begin bad++; $display("FAIL feed_timeout accepted=%0d exp=%0d", accepted, n); end
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL ready_drop got=%b exp=0", in_ready); end
    while (result_valid !== 1'b1 && lat < 50) begin
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL drain_busy got=%b exp=1", busy); end
      step(); lat++;
    end
    total++;
    if (lat != LAT) begin bad++; $display("FAIL latency got=%0d exp=%0d", lat, LAT); end
    total++;
    if (result !== AW'(ref_acc)) begin bad++; $display("FAIL result got=%0d exp=%0d", result, ref_acc); end
    held = result;
    for (int h = 0; h < hold; h++) begin
      if (noisy) begin start = 1; len = LW'($urandom_range(1, 9)); end
      step();
      total++;
      if (result_valid !== 1'b1 || result !== AW'(ref_acc)) begin
        bad++; $display("FAIL hold valid=%b got=%0d exp=%0d", result_valid, result, ref_acc);
      end
    end
    start = 0; result_ready = 1; step(); result_ready = 0;
    total++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL to_idle valid=%b busy=%b exp=0,0", result_valid, busy); end
    total++;
    if (result !== held) begin bad++; $display("FAIL result_after got=%0d exp=%0d", result, held); end
  endtask

  task automatic test_reset();
    n_rst = 0; step(); step();
    total++;
    if (in_ready !== 1'b0 || result !== '0 || result_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset ready=%b result=%0d valid=%b busy=%b exp=0", in_ready, result, result_valid, busy);
    end
    n_rst = 1; step();
  endtask

  task automatic test_basic();
    run_job(3, 0, 0, 0, 2);
  endtask

  task automatic test_bubbles();
    run_job(3, -1, 5, 0, 2);
  endtask

  task automatic test_len_zero();
    run_job(2, 0, 0, 0, 0);
    start = 1; len = '0; step(); start = 0;
    total++;
    if (result_valid !== 1'b1 || result !== '0 || in_ready !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL len_zero valid=%b result=%0d ready=%b busy=%b exp=1,0,0,1", result_valid, result, in_ready, busy);
    end
    result_ready = 1; step(); result_ready = 0;
    total++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin bad++; $display("FAIL len_zero_idle busy=%b valid=%b exp=0,0", busy, result_valid); end
  endtask

  task automatic test_wrap();
    run_job(261, 0, 1, 0, 1);
  endtask

  task automatic test_mid_reset();
    start = 1; len = LW'(5); step(); start = 0;
    in_valid = 1;
    for (int i = 0; i < 2; i++) begin in_values = $urandom; step(); end
    in_valid = 0; n_rst = 0; step(); n_rst = 1;
    total++;
    if (in_ready !== 1'b0 || result !== '0 || result_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL mid_reset ready=%b result=%0d valid=%b busy=%b exp=0", in_ready, result, result_valid, busy);
    end
    run_job(1, 0, 0, 0, 3);
  endtask

  task automatic test_ignore_start();
    run_job(6, 25, 4, 1, 0);
    step();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL start_in_done busy=%b exp=0", busy); end
  endtask

  task automatic test_idle_valid();
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      in_values = $urandom; step();
      total++;
      if (in_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL idle_valid ready=%b busy=%b exp=0,0", in_ready, busy); end
    end
    in_valid = 0;
    run_job(1, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int j = 0; j < 8; j++) run_job($urandom_range(1, 20), $urandom_range(0, 50), $urandom_range(0, 3), 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubbles();
    test_len_zero();
    test_wrap();
    test_mid_reset();
    test_ignore_start();
    test_idle_valid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
